// File: rtl/galaga_input_ctrl_pkg.sv
// Shared key codes, key-vector indices and sequencer types for the galaga input front-end.
package galaga_input_pkg;

    localparam logic [8:0] KEY_UP    = 9'h075;
    localparam logic [8:0] KEY_DOWN  = 9'h072;
    localparam logic [8:0] KEY_LEFT  = 9'h06B;
    localparam logic [8:0] KEY_RIGHT = 9'h074;
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_CTRL  = 9'h014;
    localparam logic [8:0] KEY_F1    = 9'h005;
    localparam logic [8:0] KEY_F2    = 9'h006;
    localparam logic [8:0] KEY_F3    = 9'h004;

    localparam int NUM_KEYS = 8;
    localparam int K_UP     = 0;
    localparam int K_DOWN   = 1;
    localparam int K_LEFT   = 2;
    localparam int K_RIGHT  = 3;
    localparam int K_FIRE   = 4;
    localparam int K_F1     = 5;
    localparam int K_F2     = 6;
    localparam int K_F3     = 7;

    typedef enum logic [2:0] {IDLE, COIN, GAP, START, RELEASE} seq_state_t;
    typedef enum logic [1:0] {SEL_P1, SEL_P2, SEL_COIN} seq_sel_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/galaga_input_ctrl_ps2_key_latch.sv
// PS/2 event detector: a change of the toggle bit marks one key event, which sets
// or clears the matching held-key latch with the pressed flag.
module ps2_key_latch
    import galaga_input_pkg::*;
(
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [10:0]         ps2_key,
    output logic [NUM_KEYS-1:0] keys
);

    logic                old_toggle;
    logic                key_event;
    logic                pressed;
    logic [8:0]          code;
    logic [NUM_KEYS-1:0] hit;

    assign key_event = ps2_key[10] != old_toggle;
    assign pressed   = ps2_key[9];
    assign code      = ps2_key[8:0];

    // Arrow keys arrive with or without the E0 prefix, so bit 8 is ignored for them only.
    always_comb begin
        hit         = '0;
        hit[K_UP]    = code[7:0] == KEY_UP[7:0];
        hit[K_DOWN]  = code[7:0] == KEY_DOWN[7:0];
        hit[K_LEFT]  = code[7:0] == KEY_LEFT[7:0];
        hit[K_RIGHT] = code[7:0] == KEY_RIGHT[7:0];
        hit[K_FIRE]  = (code == KEY_SPACE) || (code == KEY_CTRL);
        hit[K_F1]    = code == KEY_F1;
        hit[K_F2]    = code == KEY_F2;
        hit[K_F3]    = code == KEY_F3;
    end

    // Capturing the live toggle in reset keeps its reset-time value from looking like an event.
    always_ff @(posedge clk_sys) begin
        old_toggle <= ps2_key[10];
        if (reset) begin
            keys <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (key_event && hit[i]) begin
                    keys[i] <= pressed;
                end
            end
        end
    end

endmodule

// File: rtl/galaga_input_ctrl.sv
// Galaga control front-end: merges PS/2 keys with joystick bits, applies the
// horizontal remap and sequences coin/start pulses from a single start press.
//
// state   | meaning
// IDLE    | waiting for a start/coin request
// COIN    | coin high for COIN_PULSE cycles
// GAP     | all pulses low for START_DELAY cycles
// START   | start1 or start2 high for START_PULSE cycles
// RELEASE | waiting for the requesting button to be let go
module galaga_input_ctrl
    import galaga_input_pkg::*;
#(
    parameter int COIN_PULSE  = 1843200,
    parameter int START_DELAY = 3686400,
    parameter int START_PULSE = 1843200
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rot_horz,
    output logic        left1,
    output logic        right1,
    output logic        fire1,
    output logic        start1,
    output logic        start2,
    output logic        coin,
    output logic        busy
);

    localparam int CNT_W = $clog2(max3(COIN_PULSE, START_DELAY, START_PULSE)) + 1;
    localparam logic [CNT_W-1:0] COIN_TC  = CNT_W'(COIN_PULSE - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(START_DELAY - 1);
    localparam logic [CNT_W-1:0] START_TC = CNT_W'(START_PULSE - 1);

    logic [NUM_KEYS-1:0] keys;

    ps2_key_latch u_key_latch (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .keys    (keys)
    );

    logic lvl_p1, lvl_p2, lvl_coin;
    logic lvl_p1_q, lvl_p2_q, lvl_coin_q;
    logic req1, req2, reqc;

    assign lvl_p1   = keys[K_F1] | joy[5];
    assign lvl_p2   = keys[K_F2] | joy[6];
    assign lvl_coin = keys[K_F3] | joy[7];

    assign req1 = lvl_p1   & ~lvl_p1_q;
    assign req2 = lvl_p2   & ~lvl_p2_q;
    assign reqc = lvl_coin & ~lvl_coin_q;

    // Edge history tracks the live level even in reset, so a button held through
    // reset must be released and pressed again before it requests anything.
    always_ff @(posedge clk_sys) begin
        lvl_p1_q   <= lvl_p1;
        lvl_p2_q   <= lvl_p2;
        lvl_coin_q <= lvl_coin;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            left1  <= 1'b0;
            right1 <= 1'b0;
            fire1  <= 1'b0;
        end else begin
            left1  <= rot_horz ? (keys[K_DOWN] | joy[2]) : (keys[K_LEFT]  | joy[1]);
            right1 <= rot_horz ? (keys[K_UP]   | joy[3]) : (keys[K_RIGHT] | joy[0]);
            fire1  <= keys[K_FIRE] | joy[4];
        end
    end

    seq_state_t       state, state_nx;
    seq_sel_t         sel, sel_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             src_lvl;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= IDLE;
            sel   <= SEL_P1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        case (sel)
            SEL_P1:  src_lvl = lvl_p1;
            SEL_P2:  src_lvl = lvl_p2;
            default: src_lvl = lvl_coin;
        endcase
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (req1) begin
                    sel_nx   = SEL_P1;
                    state_nx = COIN;
                end else if (req2) begin
                    sel_nx   = SEL_P2;
                    state_nx = COIN;
                end else if (reqc) begin
                    sel_nx   = SEL_COIN;
                    state_nx = COIN;
                end
            end
            COIN: begin
                if (cnt == COIN_TC) begin
                    cnt_nx   = '0;
                    state_nx = (sel == SEL_COIN) ? RELEASE : GAP;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_TC) begin
                    cnt_nx   = '0;
                    state_nx = START;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            START: begin
                if (cnt == START_TC) begin
                    cnt_nx   = '0;
                    state_nx = RELEASE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!src_lvl) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Pulses decode straight from registered state, so they are mutually exclusive by construction.
    assign coin   = state == COIN;
    assign start1 = (state == START) && (sel == SEL_P1);
    assign start2 = (state == START) && (sel == SEL_P2);
    assign busy   = state != IDLE;

endmodule

// File: tb/tb_galaga_input_ctrl.sv
// Directed bench for galaga_input_ctrl with short pulse parameters (4/6/3).
module tb_galaga_input_ctrl;
    import galaga_input_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joy;
    logic        rot_horz;
    logic        left1, right1, fire1, start1, start2, coin, busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic tgl;

    always #5 clk_sys = ~clk_sys;

    galaga_input_ctrl #(
        .COIN_PULSE  (4),
        .START_DELAY (6),
        .START_PULSE (3)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_key  (ps2_key),
        .joy      (joy),
        .rot_horz (rot_horz),
        .left1    (left1),
        .right1   (right1),
        .fire1    (fire1),
        .start1   (start1),
        .start2   (start2),
        .coin     (coin),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ps2_event(input logic pressed, input logic [8:0] code);
        tgl     = ~tgl;
        ps2_key = {tgl, pressed, code};
    endtask

    // Cycle i counts edges after the request: coin 1..4, gap 5..10, start 11..13.
    task automatic check_seq(input int i, input int exp_start, input int busy_last);
        logic in_start;
        in_start = (i >= 11) && (i <= 13);
        check($sformatf("coin@%0d", i),   coin,   (i >= 1) && (i <= 4));
        check($sformatf("start1@%0d", i), start1, (exp_start == 1) && in_start);
        check($sformatf("start2@%0d", i), start2, (exp_start == 2) && in_start);
        check($sformatf("busy@%0d", i),   busy,   (i >= 1) && (i <= busy_last));
    endtask

    initial begin
        reset    = 1'b1;
        tgl      = 1'b1;
        ps2_key  = {1'b1, 1'b1, KEY_LEFT};
        joy      = '0;
        rot_horz = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        tick();
        check("rst_left1",  left1,  0);
        check("rst_right1", right1, 0);
        check("rst_fire1",  fire1,  0);
        check("rst_start1", start1, 0);
        check("rst_start2", start2, 0);
        check("rst_coin",   coin,   0);
        check("rst_busy",   busy,   0);
        tick(); tick();
        check("no_reset_event", left1, 0);

        ps2_event(1'b1, KEY_LEFT);
        tick();
        check("left_latency", left1, 0);
        tick();
        check("left_press", left1, 1);
        ps2_event(1'b0, KEY_LEFT);
        tick(); tick();
        check("left_release", left1, 0);

        ps2_event(1'b1, 9'h16B);
        tick(); tick();
        check("left_ext_press", left1, 1);
        ps2_event(1'b0, 9'h16B);
        tick(); tick();
        check("left_ext_release", left1, 0);

        ps2_event(1'b1, KEY_RIGHT);
        tick(); tick();
        check("right_press", right1, 1);
        ps2_event(1'b0, KEY_RIGHT);
        tick(); tick();
        check("right_release", right1, 0);

        ps2_event(1'b1, KEY_SPACE);
        tick(); tick();
        check("fire_space", fire1, 1);
        ps2_event(1'b0, KEY_SPACE);
        tick(); tick();
        check("fire_space_rel", fire1, 0);

        ps2_event(1'b1, KEY_CTRL);
        tick(); tick();
        check("fire_ctrl", fire1, 1);
        ps2_event(1'b0, KEY_CTRL);
        tick(); tick();
        check("fire_ctrl_rel", fire1, 0);

        ps2_event(1'b1, 9'h114);
        tick(); tick();
        check("fire_ext_ctrl_ignored", fire1, 0);
        ps2_event(1'b0, 9'h114);

        ps2_event(1'b1, 9'h01A);
        tick(); tick();
        check("unknown_left1",  left1,  0);
        check("unknown_right1", right1, 0);
        check("unknown_fire1",  fire1,  0);
        check("unknown_busy",   busy,   0);
        ps2_event(1'b0, 9'h01A);

        rot_horz = 1'b1;
        joy      = 16'h0008;
        tick(); tick();
        check("horz_up_right1", right1, 1);
        check("horz_up_left1",  left1,  0);
        rot_horz = 1'b0;
        tick(); tick();
        check("vert_up_right1", right1, 0);
        check("vert_up_left1",  left1,  0);
        joy = 16'h0002;
        tick(); tick();
        check("vert_joy_left", left1, 1);
        joy      = '0;
        rot_horz = 1'b1;
        ps2_event(1'b1, KEY_DOWN);
        tick(); tick();
        check("horz_down_left1", left1, 1);
        ps2_event(1'b0, KEY_DOWN);
        rot_horz = 1'b0;
        tick(); tick();
        check("horz_down_rel", left1, 0);

        // One-cycle joystick start1 pulse
        joy = 16'h0020;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_seq(i, 1, 14);
            if (i == 1) joy = '0;
        end

        // F1 key and joy start2 rising together; F2 key during the gap is dropped
        ps2_event(1'b1, KEY_F1);
        tick();
        joy = 16'h0040;
        for (int i = 1; i <= 18; i++) begin
            tick();
            check_seq(i, 1, 14);
            if (i == 6) ps2_event(1'b1, KEY_F2);
            if (i == 8) ps2_event(1'b0, KEY_F1);
        end
        joy = '0;
        ps2_event(1'b0, KEY_F2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("after_p2_busy@%0d", i), busy, 0);
        end

        // Held coin button: one coin pulse, busy until release, no retrigger
        joy = 16'h0080;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_seq(i, 0, 10);
            if (i == 10) joy = '0;
        end

        // Reset in the middle of START with start1 held through it
        joy = 16'h0020;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_seq(i, 1, 99);
        end
        reset = 1'b1;
        tick();
        check("rst_mid_start1", start1, 0);
        check("rst_mid_busy",   busy,   0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("held_no_retrig_busy@%0d", i), busy, 0);
            check($sformatf("held_no_retrig_coin@%0d", i), coin, 0);
        end
        joy = '0;
        tick(); tick();
        joy = 16'h0020;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_seq(i, 1, 14);
            if (i == 2) joy = '0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
